updown_mod_counter: RTL and testbench
=====================================

// Module: updown_mod_counter
// PURPOSE
//  Parametrised up/down counter. Counts over a programmable range 0..MOD_MAX
//  and either wraps or saturates at the range ends.
//  Adds synchronous clear, parallel load, and registered wrap/borrow event pulses.
//  It replaces the fixed 4-bit up/down counter as the shared event/timing counter.
// PARAMETERS
//  WIDTH     8    counter width in bits (>=2)
//  MOD_MAX   255  highest count value; must satisfy 1 <= MOD_MAX <= 2**WIDTH-1
//  SATURATE  0    0 = wrap at range ends; 1 = hold at range ends
// PORTS
//  clk       in   1      rising-edge clock
//  rst_n     in   1      asynchronous, active-low reset
//  clear     in   1      synchronous clear to 0 (highest priority)
//  load      in   1      synchronous parallel load of load_val
//  load_val  in   WIDTH  load value; clamped to MOD_MAX
//  enable    in   1      count enable
//  up_down   in   1      1 = count up, 0 = count down
//  count     out  WIDTH  current count (registered)
//  wrap      out  1      1-cycle pulse: an up-count went from MOD_MAX to 0 (SATURATE=0)
//  borrow    out  1      1-cycle pulse: a down-count went from 0 to MOD_MAX (SATURATE=0)
//  sat       out  1      1-cycle pulse: a count was blocked at a range end (SATURATE=1)
//  at_max    out  1      count == MOD_MAX (combinational decode of count)
//  at_min    out  1      count == 0 (combinational decode of count)
// BEHAVIOUR
//  - Reset: rst_n low forces count=0, wrap=0, borrow=0, sat=0 at once, with no
//    clock edge needed. Consequently at_min=1 and at_max=0 during reset.
//    Reset may be applied mid-count. Counting restarts on the first clk edge
//    after rst_n is released.
//  - Priority on each rising clk edge:
//    clear > load > enable > hold.
//  - clear=1: count<=0. No pulse is generated.
//  - load=1 (clear=0): count <= min(load_val, MOD_MAX). No pulse is generated.
//    enable is ignored in that cycle.
//  - enable=1, up_down=1:
//    - count<MOD_MAX: count<=count+1.
//    - count==MOD_MAX, SATURATE=0: count<=0 and wrap=1.
//    - count==MOD_MAX, SATURATE=1: count holds and sat=1.
//  - enable=1, up_down=0:
//    - count>0: count<=count-1.
//    - count==0, SATURATE=0: count<=MOD_MAX and borrow=1.
//    - count==0, SATURATE=1: count holds and sat=1.
//  - enable=0: count holds and all pulses are 0.
//  - Pulse timing: wrap, borrow and sat are registered. Each is high for exactly
//    the cycle after the edge that caused it, i.e. aligned with the new count.
//    The pulses are mutually exclusive.
//  - Latency: count updates 1 cycle after its inputs are sampled. There is no
//    pipelining, and an input change takes effect on the next edge.
//  - Direction change: up_down may toggle on any cycle. The next step uses the
//    new direction, with no dead cycle.
//  - Arithmetic: increment and decrement are modulo MOD_MAX+1 (wrap mode) and
//    never pass through values above MOD_MAX. Counting must never produce a
//    value above MOD_MAX.
//  - MOD_MAX==2**WIDTH-1 must give natural binary rollover.
// TESTING (WIDTH=4, MOD_MAX=9 unless noted)
//  1. rst_n=0 with enable=1, up_down=1 -> count=0 immediately, at_min=1, all pulses 0.
//     Release rst_n and count 12 clk edges -> 1..9,0,1,2. wrap=1 only with count=0.
//  2. up_down=0 starting from count=2, 4 edges -> 1,0,9,8.
//     borrow=1 only in the cycle count=9.
//  3. SATURATE=1: up from 8, 3 edges -> 9,9,9 with sat=1 on the 2nd and 3rd cycles.
//     Down from 1, 3 edges -> 0,0,0 with sat=1 on the 2nd and 3rd cycles.
//  4. load=1, load_val=12 -> count=9, at_max=1.
//     Assert load and clear together -> count=0.
//     load with enable=1 -> loaded value, no step.
//  5. enable=0 for 5 cycles at count=5 -> count stays 5, no pulses.
//     Drop rst_n mid-cycle at count=7 -> count=0 before the next clk edge.
//  6. WIDTH=4, MOD_MAX=15: count up from 14, 3 edges -> 15,0,1 with wrap=1.
//     Random enable/up_down/load stimulus for 10k cycles -> count <= MOD_MAX always.

Source files
------------

// File: rtl/updown_mod_counter.sv
// ----------------------------------------------------------------------------
// updown_mod_counter
//
// Purpose:
//   Parametrised up/down counter over the range 0..MOD_MAX. At a range end the
//   counter either wraps (SATURATE=0) or holds (SATURATE=1). It also supports
//   a synchronous clear, a parallel load clamped to MOD_MAX, and registered
//   one-cycle event pulses that line up with the count value they describe.
//
// Parameters:
//   WIDTH     counter width in bits (>= 2)
//   MOD_MAX   highest count value, 1 <= MOD_MAX <= 2**WIDTH-1
//   SATURATE  0 = wrap at the range ends, 1 = hold at the range ends
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset (count and pulses go to 0)
//   clear     synchronous clear to 0, highest priority
//   load      synchronous load of min(load_val, MOD_MAX)
//   load_val  value to load
//   enable    count enable
//   up_down   1 = count up, 0 = count down
//   count     registered count
//   wrap      pulse: an up-step went from MOD_MAX to 0
//   borrow    pulse: a down-step went from 0 to MOD_MAX
//   sat       pulse: a step was blocked at a range end
//   at_max    count == MOD_MAX
//   at_min    count == 0
//
// Per-edge priority: clear > load > enable > hold.
// ----------------------------------------------------------------------------
module updown_mod_counter #(
    parameter int WIDTH    = 8,
    parameter int MOD_MAX  = 255,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             enable,
    input  logic             up_down,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             borrow,
    output logic             sat,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] MAX_V  = MOD_MAX[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ZERO_V = '0;
    localparam logic [WIDTH-1:0] ONE_V  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             borrow_q;
    logic             borrow_d;
    logic             sat_q;
    logic             sat_d;
    logic             is_max;
    logic             is_min;
    logic [WIDTH-1:0] load_clamped;

    assign is_max = (count_q == MAX_V);
    assign is_min = (count_q == ZERO_V);

    // Out-of-range load values land on MOD_MAX so the count never leaves
    // the programmed range, even when it is loaded directly.
    assign load_clamped = (load_val > MAX_V) ? MAX_V : load_val;

    // Next-state and pulse decode. The range ends are detected by explicit
    // compares rather than relying on arithmetic overflow, so increments and
    // decrements never pass through values above MOD_MAX. When MOD_MAX is
    // the all-ones value this reduces to ordinary binary rollover.
    always_comb begin
        count_d  = count_q;
        wrap_d   = 1'b0;
        borrow_d = 1'b0;
        sat_d    = 1'b0;

        if (clear) begin
            count_d = ZERO_V;
        end else if (load) begin
            count_d = load_clamped;
        end else if (enable) begin
            if (up_down) begin
                if (!is_max) begin
                    count_d = count_q + ONE_V;
                end else if (SATURATE) begin
                    sat_d = 1'b1;
                end else begin
                    count_d = ZERO_V;
                    wrap_d  = 1'b1;
                end
            end else begin
                if (!is_min) begin
                    count_d = count_q - ONE_V;
                end else if (SATURATE) begin
                    sat_d = 1'b1;
                end else begin
                    count_d  = MAX_V;
                    borrow_d = 1'b1;
                end
            end
        end
    end

    // Pulses are registered alongside the count, so each one is high in
    // exactly the cycle that shows the count value produced by its event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= ZERO_V;
            wrap_q   <= 1'b0;
            borrow_q <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            wrap_q   <= wrap_d;
            borrow_q <= borrow_d;
            sat_q    <= sat_d;
        end
    end

    assign count  = count_q;
    assign wrap   = wrap_q;
    assign borrow = borrow_q;
    assign sat    = sat_q;
    assign at_max = is_max;
    assign at_min = is_min;

endmodule

// File: tb/tb_updown_mod_counter.sv
// ----------------------------------------------------------------------------
// tb_updown_mod_counter
//
// Three counters share clk and rst_n:
//   index 0: WIDTH=4, MOD_MAX=9,  SATURATE=0
//   index 1: WIDTH=4, MOD_MAX=9,  SATURATE=1
//   index 2: WIDTH=4, MOD_MAX=15, SATURATE=0
// Inputs are driven 1 ns after a rising edge; outputs are sampled at that
// same point, well away from the next active edge.
// ----------------------------------------------------------------------------
module tb_updown_mod_counter;

    logic       clk;
    logic       rst_n;
    logic       clear_v    [3];
    logic       load_v     [3];
    logic [3:0] load_val_v [3];
    logic       enable_v   [3];
    logic       up_down_v  [3];
    logic [3:0] count_v    [3];
    logic       wrap_v     [3];
    logic       borrow_v   [3];
    logic       sat_v      [3];
    logic       at_max_v   [3];
    logic       at_min_v   [3];

    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    updown_mod_counter #(.WIDTH(4), .MOD_MAX(9), .SATURATE(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear_v[0]), .load(load_v[0]),
        .load_val(load_val_v[0]), .enable(enable_v[0]), .up_down(up_down_v[0]),
        .count(count_v[0]), .wrap(wrap_v[0]), .borrow(borrow_v[0]), .sat(sat_v[0]),
        .at_max(at_max_v[0]), .at_min(at_min_v[0])
    );

    updown_mod_counter #(.WIDTH(4), .MOD_MAX(9), .SATURATE(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .clear(clear_v[1]), .load(load_v[1]),
        .load_val(load_val_v[1]), .enable(enable_v[1]), .up_down(up_down_v[1]),
        .count(count_v[1]), .wrap(wrap_v[1]), .borrow(borrow_v[1]), .sat(sat_v[1]),
        .at_max(at_max_v[1]), .at_min(at_min_v[1])
    );

    updown_mod_counter #(.WIDTH(4), .MOD_MAX(15), .SATURATE(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .clear(clear_v[2]), .load(load_v[2]),
        .load_val(load_val_v[2]), .enable(enable_v[2]), .up_down(up_down_v[2]),
        .count(count_v[2]), .wrap(wrap_v[2]), .borrow(borrow_v[2]), .sat(sat_v[2]),
        .at_max(at_max_v[2]), .at_min(at_min_v[2])
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic clr, input logic ld, input int lv,
                         input logic en, input logic ud);
        clear_v[d]    = clr;
        load_v[d]     = ld;
        load_val_v[d] = 4'(lv);
        enable_v[d]   = en;
        up_down_v[d]  = ud;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Checks count and the {wrap,borrow,sat} pulse vector of one counter.
    task automatic chk_dut(input string tag, input int d, input int exp_cnt,
                           input logic [2:0] exp_p);
        chk({tag, ".count"}, 32'(count_v[d]), 32'(exp_cnt));
        chk({tag, ".pulses"}, 32'({wrap_v[d], borrow_v[d], sat_v[d]}), 32'(exp_p));
    endtask

    // Reference behaviour for the random phase, pulses as {wrap,borrow,sat}.
    function automatic void model_step(input int cur, input bit clr, input bit ld,
                                       input int lv, input bit en, input bit ud,
                                       input int mx, input bit sm,
                                       output int nxt, output logic [2:0] p);
        nxt = cur;
        p   = 3'b000;
        if (clr) nxt = 0;
        else if (ld) nxt = (lv > mx) ? mx : lv;
        else if (en) begin
            if (ud) begin
                if (cur < mx) nxt = cur + 1;
                else if (sm) p = 3'b001;
                else begin nxt = 0; p = 3'b100; end
            end else begin
                if (cur > 0) nxt = cur - 1;
                else if (sm) p = 3'b001;
                else begin nxt = mx; p = 3'b010; end
            end
        end
    endfunction

    // ---------------- directed + random stimulus ----------------
    int         t1_cnt [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int         t2_cnt [4]  = '{1, 0, 9, 8};
    int         max_v  [3]  = '{9, 9, 15};
    bit         sat_m  [3]  = '{1'b0, 1'b1, 1'b0};
    int         exp_cnt [3];
    logic [2:0] exp_p   [3];

    initial begin
        rst_n = 1'b1;
        for (int d = 0; d < 3; d++) drive(d, 0, 0, 0, 0, 0);

        // 1. reset takes effect without a clock edge, even with enable high
        drive(0, 0, 0, 0, 1, 1);
        #2 rst_n = 1'b0;
        #1;
        chk_dut("rst_async", 0, 0, 3'b000);
        chk("rst_at_min", 32'(at_min_v[0]), 1);
        chk("rst_at_max", 32'(at_max_v[0]), 0);
        tick();
        tick();
        chk_dut("rst_held", 0, 0, 3'b000);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk_dut($sformatf("up_%0d", k), 0, t1_cnt[k], (k == 9) ? 3'b100 : 3'b000);
        end

        // 2. down-count from 2 through the borrow
        drive(0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_dut($sformatf("down_%0d", k), 0, t2_cnt[k], (k == 2) ? 3'b010 : 3'b000);
            if (k == 2) chk("down_at_max", 32'(at_max_v[0]), 1);
        end
        drive(0, 0, 0, 0, 0, 0);

        // 3. saturating instance
        drive(1, 0, 1, 8, 0, 0);
        tick();
        chk_dut("sat_load8", 1, 8, 3'b000);
        drive(1, 0, 0, 0, 1, 1);
        tick(); chk_dut("sat_up0", 1, 9, 3'b000);
        tick(); chk_dut("sat_up1", 1, 9, 3'b001);
        tick(); chk_dut("sat_up2", 1, 9, 3'b001);
        drive(1, 0, 1, 1, 1, 0);
        tick(); chk_dut("sat_load1", 1, 1, 3'b000);
        drive(1, 0, 0, 0, 1, 0);
        tick(); chk_dut("sat_dn0", 1, 0, 3'b000);
        tick(); chk_dut("sat_dn1", 1, 0, 3'b001);
        tick(); chk_dut("sat_dn2", 1, 0, 3'b001);
        drive(1, 0, 0, 0, 0, 0);
        tick(); chk_dut("sat_idle", 1, 0, 3'b000);

        // 6. full-range instance: natural rollover both ways
        drive(2, 0, 1, 14, 0, 0);
        tick(); chk_dut("full_load14", 2, 14, 3'b000);
        drive(2, 0, 0, 0, 1, 1);
        tick(); chk_dut("full_up0", 2, 15, 3'b000);
        chk("full_at_max", 32'(at_max_v[2]), 1);
        tick(); chk_dut("full_up1", 2, 0, 3'b100);
        tick(); chk_dut("full_up2", 2, 1, 3'b000);
        drive(2, 0, 0, 0, 1, 0);
        tick(); chk_dut("full_dn0", 2, 0, 3'b000);
        tick(); chk_dut("full_dn1", 2, 15, 3'b010);
        drive(2, 0, 0, 0, 0, 0);

        // 4. load clamping and priorities
        drive(0, 0, 1, 12, 0, 0);
        tick(); chk_dut("load_clamp", 0, 9, 3'b000);
        chk("load_at_max", 32'(at_max_v[0]), 1);
        drive(0, 1, 1, 5, 0, 0);
        tick(); chk_dut("clear_over_load", 0, 0, 3'b000);
        chk("clear_at_min", 32'(at_min_v[0]), 1);
        drive(0, 0, 1, 3, 1, 1);
        tick(); chk_dut("load_over_en", 0, 3, 3'b000);
        drive(0, 0, 1, 9, 0, 0);
        tick(); chk_dut("load_max", 0, 9, 3'b000);
        drive(0, 1, 0, 0, 1, 1);
        tick(); chk_dut("clear_over_wrap", 0, 0, 3'b000);

        // 5. hold with enable low, then reset mid-cycle
        drive(0, 0, 1, 5, 0, 0);
        tick(); chk_dut("hold_load5", 0, 5, 3'b000);
        drive(0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_dut($sformatf("hold_%0d", k), 0, 5, 3'b000);
        end
        drive(0, 0, 1, 7, 0, 0);
        tick(); chk_dut("pre_rst7", 0, 7, 3'b000);
        drive(0, 0, 0, 0, 1, 1);
        #3 rst_n = 1'b0;
        #1;
        chk_dut("rst_mid", 0, 0, 3'b000);
        tick();
        chk_dut("rst_mid_held", 0, 0, 3'b000);
        rst_n = 1'b1;
        tick(); chk_dut("restart", 0, 1, 3'b000);
        // direction change with no dead cycle
        drive(0, 0, 0, 0, 1, 0);
        tick(); chk_dut("dir_dn", 0, 0, 3'b000);
        drive(0, 0, 0, 0, 1, 1);
        tick(); chk_dut("dir_up", 0, 1, 3'b000);

        // random phase: all counters, checked against the reference model
        for (int d = 0; d < 3; d++) drive(d, 1, 0, 0, 0, 0);
        tick();
        for (int d = 0; d < 3; d++) exp_cnt[d] = 0;
        for (int n = 0; n < 10000; n++) begin
            for (int d = 0; d < 3; d++) begin
                drive(d, $urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
                      int'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
                      1'($urandom_range(0, 1)));
                model_step(exp_cnt[d], clear_v[d], load_v[d], int'(load_val_v[d]),
                           enable_v[d], up_down_v[d], max_v[d], sat_m[d],
                           exp_cnt[d], exp_p[d]);
            end
            tick();
            for (int d = 0; d < 3; d++) begin
                chk_dut($sformatf("rnd%0d", d), d, exp_cnt[d], exp_p[d]);
                chk($sformatf("rnd%0d.bound", d), 32'(int'(count_v[d]) <= max_v[d]), 1);
            end
        end

        // ---------------- final report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
